uart_core: RTL and testbench

UART_CORE -- requirements
Module: uart_core

---
 rtl/uart_core_if.sv | 22 ++
 rtl/uart_core.sv | 200 ++++++++++++++++++++
 tb/tb_uart_core.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_core_if.sv
// Byte/trigger/serial bundle between uart_core and its user.
// The serial lines ride here too, so one modport pair covers the whole block.
interface uart_core_if;
    logic       RX;
    logic       TX;
    logic [7:0] DATA_IN;
    logic [7:0] DATA_OUT;
    logic       TRG_WRITE;
    logic       TRG_READ;
    logic       FLOW;
    logic       DONE;

    modport master (
        output RX, DATA_IN, TRG_WRITE, TRG_READ, FLOW,
        input  TX, DATA_OUT, DONE
    );

    modport slave (
        input  RX, DATA_IN, TRG_WRITE, TRG_READ, FLOW,
        output TX, DATA_OUT, DONE
    );
endinterface

// File: rtl/uart_core.sv
// Full-duplex 8N1 UART: edge-triggered single-byte transmitter plus a
// mid-bit sampling receiver with optional arm-before-receive mode.
module uart_core #(
    parameter int unsigned CLK_HZ = 50000000,
    parameter int unsigned BAUD   = 115200
) (
    input logic        CLK_50MHZ,
    input logic        RST,
    uart_core_if.slave bus
);
    localparam int unsigned DIV   = CLK_HZ / BAUD;
    localparam int unsigned HALF  = DIV / 2;
    localparam int unsigned CNT_W = $clog2(DIV + 1);
    localparam logic [CNT_W-1:0] DIV_LAST  = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF - 1);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_e;

    state_e             tx_state_q, tx_state_d;
    logic [CNT_W-1:0]   tx_cnt_q, tx_cnt_d;
    logic [2:0]         tx_bit_q, tx_bit_d;
    logic [7:0]         tx_data_q, tx_data_d;
    logic               tx_q, tx_d;
    logic               tx_done;

    state_e             rx_state_q, rx_state_d;
    logic [CNT_W-1:0]   rx_cnt_q, rx_cnt_d;
    logic [2:0]         rx_bit_q, rx_bit_d;
    logic [7:0]         rx_shift_q, rx_shift_d;
    logic [7:0]         dout_q, dout_d;
    logic               armed_q, armed_d;
    logic               rx_done;
    logic               done_q, done_d;

    logic               wr_prev_q, wr_low_seen_q, rd_prev_q;
    logic               rx_s1_q, rx_s2_q, rx_prev_q;
    logic               wr_edge, rd_edge, rx_en;

    // A write needs TRG_WRITE to have been seen low since reset, so a level held through reset is not a write
    assign wr_edge = bus.TRG_WRITE & ~wr_prev_q & wr_low_seen_q;
    assign rd_edge = bus.TRG_READ & ~rd_prev_q;
    assign rx_en   = bus.FLOW | armed_q;

    assign bus.TX       = tx_q;
    assign bus.DATA_OUT = dout_q;
    assign bus.DONE     = done_q;

    always_ff @(posedge CLK_50MHZ or posedge RST) begin
        if (RST) begin
            tx_state_q    <= S_IDLE;
            tx_cnt_q      <= '0;
            tx_bit_q      <= '0;
            tx_data_q     <= '0;
            tx_q          <= 1'b1;
            rx_state_q    <= S_IDLE;
            rx_cnt_q      <= '0;
            rx_bit_q      <= '0;
            rx_shift_q    <= '0;
            dout_q        <= '0;
            armed_q       <= 1'b0;
            done_q        <= 1'b0;
            wr_prev_q     <= 1'b0;
            wr_low_seen_q <= 1'b0;
            rd_prev_q     <= 1'b0;
            rx_s1_q       <= 1'b1;
            rx_s2_q       <= 1'b1;
            rx_prev_q     <= 1'b1;
        end else begin
            tx_state_q    <= tx_state_d;
            tx_cnt_q      <= tx_cnt_d;
            tx_bit_q      <= tx_bit_d;
            tx_data_q     <= tx_data_d;
            tx_q          <= tx_d;
            rx_state_q    <= rx_state_d;
            rx_cnt_q      <= rx_cnt_d;
            rx_bit_q      <= rx_bit_d;
            rx_shift_q    <= rx_shift_d;
            dout_q        <= dout_d;
            armed_q       <= armed_d;
            done_q        <= done_d;
            wr_prev_q     <= bus.TRG_WRITE;
            wr_low_seen_q <= wr_low_seen_q | ~bus.TRG_WRITE;
            rd_prev_q     <= bus.TRG_READ;
            rx_s1_q       <= bus.RX;
            rx_s2_q       <= rx_s1_q;
            rx_prev_q     <= rx_s2_q;
        end
    end

    // Transmitter: each of START, 8x DATA, STOP lasts DIV cycles
    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_bit_d   = tx_bit_q;
        tx_data_d  = tx_data_q;
        tx_done    = 1'b0;
        tx_d       = 1'b1;
        case (tx_state_q)
            S_IDLE: begin
                if (wr_edge) begin
                    tx_state_d = S_START;
                    tx_data_d  = bus.DATA_IN;
                    tx_cnt_d   = '0;
                end
            end
            S_START: begin
                if (tx_cnt_q == DIV_LAST) begin
                    tx_state_d = S_DATA;
                    tx_cnt_d   = '0;
                    tx_bit_d   = '0;
                end else begin
                    tx_cnt_d = tx_cnt_q + CNT_W'(1);
                end
            end
            S_DATA: begin
                if (tx_cnt_q == DIV_LAST) begin
                    tx_cnt_d = '0;
                    if (tx_bit_q == 3'd7) tx_state_d = S_STOP;
                    else                  tx_bit_d   = tx_bit_q + 3'd1;
                end else begin
                    tx_cnt_d = tx_cnt_q + CNT_W'(1);
                end
            end
            S_STOP: begin
                if (tx_cnt_q == DIV_LAST) begin
                    tx_state_d = S_IDLE;
                    tx_cnt_d   = '0;
                    tx_done    = 1'b1;
                end else begin
                    tx_cnt_d = tx_cnt_q + CNT_W'(1);
                end
            end
            default: tx_state_d = S_IDLE;
        endcase
        // Line level follows the state being entered so TX stays a clean register output
        case (tx_state_d)
            S_START: tx_d = 1'b0;
            S_DATA:  tx_d = tx_data_d[tx_bit_d];
            default: tx_d = 1'b1;
        endcase
    end

    // Receiver: confirm start at half bit, then sample every DIV cycles
    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        dout_d     = dout_q;
        rx_done    = 1'b0;
        case (rx_state_q)
            S_IDLE: begin
                if (rx_en && rx_prev_q && !rx_s2_q) begin
                    rx_state_d = S_START;
                    rx_cnt_d   = '0;
                end
            end
            S_START: begin
                if (rx_cnt_q == HALF_LAST) begin
                    rx_cnt_d   = '0;
                    rx_bit_d   = '0;
                    rx_state_d = rx_s2_q ? S_IDLE : S_DATA;
                end else begin
                    rx_cnt_d = rx_cnt_q + CNT_W'(1);
                end
            end
            S_DATA: begin
                if (rx_cnt_q == DIV_LAST) begin
                    rx_cnt_d   = '0;
                    rx_shift_d = {rx_s2_q, rx_shift_q[7:1]};
                    if (rx_bit_q == 3'd7) rx_state_d = S_STOP;
                    else                  rx_bit_d   = rx_bit_q + 3'd1;
                end else begin
                    rx_cnt_d = rx_cnt_q + CNT_W'(1);
                end
            end
            S_STOP: begin
                if (rx_cnt_q == DIV_LAST) begin
                    rx_state_d = S_IDLE;
                    rx_cnt_d   = '0;
                    if (rx_s2_q) begin
                        dout_d  = rx_shift_q;
                        rx_done = 1'b1;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q + CNT_W'(1);
                end
            end
            default: rx_state_d = S_IDLE;
        endcase
    end

    // Arming: a fresh TRG_READ wins over a same-cycle capture clear
    always_comb begin
        armed_d = armed_q;
        if (rx_done) armed_d = 1'b0;
        if (rd_edge) armed_d = 1'b1;
        done_d = tx_done | rx_done;
    end
endmodule

// File: tb/tb_uart_core.sv
// Randomized bench for uart_core: serial frames are built and decoded from
// the 8N1 rules and checked against a small byte/arm-flag model.
module tb_uart_core;
    localparam int unsigned DIV  = 50000000 / 115200;
    localparam int unsigned HALF = DIV / 2;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    int   done_times[$];
    logic [7:0] exp_dout;
    bit   armed_m;

    uart_core_if bus();

    uart_core #(.CLK_HZ(50000000), .BAUD(115200)) dut (
        .CLK_50MHZ (clk),
        .RST       (rst),
        .bus       (bus.slave)
    );

    always #10 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (bus.DONE === 1'b1) done_times.push_back(cyc);

    initial begin
        #(20 * 97000);
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic wait_until(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic pulse_write(input logic [7:0] b, input int len);
        @(negedge clk);
        bus.DATA_IN   = b;
        bus.TRG_WRITE = 1'b1;
        repeat (len) @(negedge clk);
        bus.TRG_WRITE = 1'b0;
        bus.DATA_IN   = 8'($urandom);
    endtask

    // Find the start bit, then sample the line at every bit centre
    task automatic tx_check(input string tag, input logic [7:0] b, output int t0);
        bit         seen = 1'b0;
        logic [9:0] obs;
        logic [9:0] exp;
        t0 = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (bus.TX === 1'b0) begin seen = 1'b1; t0 = cyc; end
        end
        check_eq({tag, "_start"}, 32'(seen), 32'd1);
        if (seen) begin
            repeat (HALF) @(negedge clk);
            obs[0] = bus.TX;
            for (int i = 1; i < 10; i++) begin
                repeat (DIV) @(negedge clk);
                obs[i] = bus.TX;
            end
            exp = {1'b1, b, 1'b0};
            check_eq({tag, "_bits"}, 32'(obs), 32'(exp));
        end
    endtask

    task automatic tx_case(input string tag, input logic [7:0] b, input int len);
        int t0;
        done_times.delete();
        fork
            pulse_write(b, len);
            tx_check(tag, b, t0);
        join
        wait_until(t0 + 10 * DIV + 5);
        check_eq({tag, "_done_n"}, 32'(done_times.size()), 32'd1);
        if (done_times.size() > 0)
            check_eq({tag, "_done_t"}, 32'(done_times[0]), 32'(t0 + 10 * DIV));
    endtask

    task automatic rx_send(input logic [7:0] b, input bit stop_bit, output int s);
        @(negedge clk);
        bus.RX = 1'b0;
        s = cyc;
        repeat (DIV) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            bus.RX = b[i];
            repeat (DIV) @(negedge clk);
        end
        bus.RX = stop_bit;
        repeat (DIV) @(negedge clk);
        bus.RX = 1'b1;
        repeat (DIV) @(negedge clk);
    endtask

    // Model: capture iff enabled at frame start and stop bit is 1
    task automatic rx_case(input string tag, input logic [7:0] b, input bit stop_ok);
        int s;
        bit cap;
        done_times.delete();
        cap = (bus.FLOW || armed_m) && stop_ok;
        rx_send(b, stop_ok, s);
        if (cap) begin exp_dout = b; armed_m = 1'b0; end
        check_eq({tag, "_dout"}, 32'(bus.DATA_OUT), 32'(exp_dout));
        check_eq({tag, "_done_n"}, 32'(done_times.size()), cap ? 32'd1 : 32'd0);
        if (cap && done_times.size() > 0)
            check_eq({tag, "_done_t"},
                     32'(done_times[0] >= s + 9 * DIV + HALF && done_times[0] <= s + 9 * DIV + HALF + 8),
                     32'd1);
    endtask

    task automatic read_arm();
        @(negedge clk);
        bus.TRG_READ = 1'b1;
        @(negedge clk);
        bus.TRG_READ = 1'b0;
        armed_m = 1'b1;
    endtask

    initial begin
        int         bad_tx, bad_done, t0, s, tstart;
        logic [7:0] lst [3];
        logic [7:0] rb, tb_byte;
        lst[0] = 8'h03; lst[1] = 8'h06; lst[2] = 8'h0C;

        rst = 1'b1;
        bus.RX = 1'b1; bus.DATA_IN = '0; bus.TRG_WRITE = 1'b0;
        bus.TRG_READ = 1'b0; bus.FLOW = 1'b1;
        exp_dout = 8'h00; armed_m = 1'b0;
        repeat (5) @(negedge clk);
        check_eq("rst_tx", 32'(bus.TX), 32'd1);
        check_eq("rst_done", 32'(bus.DONE), 32'd0);
        check_eq("rst_dout", 32'(bus.DATA_OUT), 32'd0);
        rst = 1'b0;

        // 10 us of idle line
        bad_tx = 0; bad_done = 0;
        repeat (500) begin
            @(negedge clk);
            if (bus.TX !== 1'b1) bad_tx++;
            if (bus.DONE !== 1'b0) bad_done++;
        end
        check_eq("idle_tx", 32'(bad_tx), 32'd0);
        check_eq("idle_done", 32'(bad_done), 32'd0);
        check_eq("idle_dout", 32'(bus.DATA_OUT), 32'd0);

        tx_case("tx03", 8'h03, 5);

        // Frames 100 us apart with an idle-high gap between them
        foreach (lst[k]) begin
            tstart = cyc;
            tx_case($sformatf("txseq%0d", k), lst[k], 1 + k);
            bad_tx = 0;
            while (cyc < tstart + 5000) begin
                @(negedge clk);
                if (bus.TX !== 1'b1) bad_tx++;
            end
            check_eq($sformatf("txgap%0d", k), 32'(bad_tx), 32'd0);
        end
        tx_case("txrand", 8'($urandom), int'($urandom_range(1, 8)));

        // Write edge mid-frame must be dropped
        done_times.delete();
        tb_byte = 8'($urandom_range(0, 254));
        fork
            begin
                pulse_write(tb_byte, 3);
                repeat (1000) @(negedge clk);
                bus.DATA_IN = 8'hFF; bus.TRG_WRITE = 1'b1;
                repeat (2) @(negedge clk);
                bus.TRG_WRITE = 1'b0;
            end
            tx_check("txign", tb_byte, t0);
        join
        wait_until(t0 + 10 * DIV + 5);
        bad_tx = 0;
        repeat (2 * DIV) begin
            @(negedge clk);
            if (bus.TX !== 1'b1) bad_tx++;
        end
        check_eq("txign_extra", 32'(bad_tx), 32'd0);
        check_eq("txign_done_n", 32'(done_times.size()), 32'd1);

        // Receiver, free-running
        bus.FLOW = 1'b1;
        rx_case("rxA5", 8'hA5, 1'b1);
        done_times.delete();
        @(negedge clk); bus.RX = 1'b0;
        repeat (5) @(negedge clk);
        bus.RX = 1'b1;
        repeat (11 * DIV) @(negedge clk);
        check_eq("glitch_done_n", 32'(done_times.size()), 32'd0);
        check_eq("glitch_dout", 32'(bus.DATA_OUT), 32'(exp_dout));
        rx_case("rxrand", 8'($urandom), 1'b1);

        // Receiver, armed mode
        bus.FLOW = 1'b0;
        rx_case("noarm", 8'h3C, 1'b1);
        read_arm();
        read_arm();
        rx_case("armed", 8'h3C, 1'b1);
        read_arm();
        rx_case("ferr", 8'($urandom), 1'b0);
        rx_case("stillarmed", 8'($urandom), 1'b1);
        rx_case("disarmed", 8'($urandom), 1'b1);

        // Full duplex
        bus.FLOW = 1'b1;
        done_times.delete();
        rb = 8'($urandom);
        tb_byte = 8'($urandom);
        fork
            pulse_write(tb_byte, 2);
            tx_check("dx_tx", tb_byte, t0);
            begin
                repeat (300) @(negedge clk);
                rx_send(rb, 1'b1, s);
            end
        join
        exp_dout = rb;
        check_eq("dx_done_n", 32'(done_times.size()), 32'd2);
        check_eq("dx_dout", 32'(bus.DATA_OUT), 32'(exp_dout));

        // Reset mid-frame, then TRG_WRITE held high through reset release
        pulse_write(8'h00, 2);
        repeat (2000) @(negedge clk);
        check_eq("mid_tx_busy", 32'(bus.TX), 32'd0);
        rst = 1'b1;
        bus.TRG_WRITE = 1'b1;
        #1;
        check_eq("mid_rst_tx", 32'(bus.TX), 32'd1);
        check_eq("mid_rst_dout", 32'(bus.DATA_OUT), 32'd0);
        exp_dout = 8'h00; armed_m = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        bad_tx = 0;
        repeat (500) begin
            @(negedge clk);
            if (bus.TX !== 1'b1) bad_tx++;
        end
        check_eq("held_wr_tx", 32'(bad_tx), 32'd0);
        bus.TRG_WRITE = 1'b0;
        repeat (3) @(negedge clk);
        tx_case("post_rst", 8'($urandom), 3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
